// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of imem_boot_loader.
// master: stream source / memory side (testbench), slave: the loader.
interface imem_boot_loader_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a little-endian byte stream into 32-bit words,
// writes them to instruction memory from byte address 0 and raises 'load'
// once the program is present.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a 4-byte XOR trailer
// check after the last word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RECV  | accepting bytes of the current word (s_ready=1)
// S_WRITE | one-cycle write strobe for the assembled word
// S_CHK   | accepting the checksum trailer (checksum build only)
// S_DONE  | program loaded (load reflects success), waiting for start
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  imem_boot_loader_if.slave    bus,
  output logic                 load,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK = 3'd4
`endif
  } state_t;

  localparam logic [LEN_W:0] DEPTH_LEN = (LEN_W+1)'(2**ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         word_q, word_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic                imem_we_q, imem_we_d;
  logic [31:0]         imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]         csum_q, csum_d;
`endif

  logic                hs;
  logic                start_ok;
  logic                len_bad;
  logic                last_word;
  logic [31:0]         word_nx;

  assign hs        = bus.s_valid && s_ready_q;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign len_bad   = ({1'b0, len} > DEPTH_LEN);
  assign last_word = (LEN_W'(word_idx_q) == len_q - LEN_W'(1));

  // Next-state and next-output logic for the load sequence.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    load_d       = load_q;
    err_d        = err_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    word_nx                          = word_q;
    word_nx[{byte_cnt_q, 3'b000} +: 8] = bus.s_data;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            len_d      = len;
            word_idx_d = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            load_d     = 1'b0;
            err_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
            // An empty program still carries a (zero) trailer.
            state_d    = (len == '0) ? S_CHK : S_RECV;
`else
            if (len == '0) begin
              state_d = S_DONE;
              load_d  = 1'b1;
            end else begin
              state_d = S_RECV;
            end
`endif
          end
        end
      end

      S_RECV: begin
        if (hs) begin
          word_d     = word_nx;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = 32'(word_idx_q) << 2;
            imem_wdata_d = word_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d       = csum_q ^ word_nx;
`endif
          end
        end
      end

      S_WRITE: begin
        byte_cnt_d = '0;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          load_d  = 1'b1;
`endif
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = S_RECV;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (hs) begin
          word_d     = word_nx;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_DONE;
            if (word_nx == csum_q) begin
              load_d = 1'b1;
            end else begin
              load_d = 1'b0;
              err_d  = 1'b1;
            end
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
    s_ready_d = (state_d == S_RECV) || (state_d == S_CHK);
    busy_d    = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHK);
`else
    s_ready_d = (state_d == S_RECV);
    busy_d    = (state_d == S_RECV) || (state_d == S_WRITE);
`endif
  end

  // State and registered outputs; synchronous reset drops any partial word.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      word_idx_q   <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      load_q       <= 1'b0;
      err_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      load_q       <= load_d;
      err_q        <= err_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign load           = load_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule
